// File: rtl/vdp_pkg.sv
// Shared constants, pixel type and state encodings for the SMS line doubler.
package vdp_pkg;

    localparam int SMS_W    = 256;
    localparam int SMS_H    = 192;
    localparam int H_BORDER = 64;
    localparam int V_BORDER = 48;

    // SMS pixel as delivered by the VDP: 2 bits per component, blue in the MSBs.
    typedef struct packed {
        logic [1:0] b;
        logic [1:0] g;
        logic [1:0] r;
    } sms_color_t;

    // Fill FSM: waiting for a line request, or capturing a scanline.
    typedef enum logic {
        IDLE,
        FILL
    } fill_state_t;

    // What the registered display stage shows for the current pixel.
    typedef enum logic [1:0] {
        REG_BLANK,
        REG_BORDER,
        REG_PICTURE
    } region_t;

    // Replicate a 2-bit component into 4 bits so full scale maps to 4'hF.
    function automatic logic [3:0] expand2(input logic [1:0] c);
        return {c, c};
    endfunction

endpackage

// File: rtl/sms_line_doubler_if.sv
// Scanline handshake between the line doubler (master, issues requests)
// and the VDP pixel pipeline (slave, streams the requested line).
interface sms_line_doubler_if;
    import vdp_pkg::*;

    logic       line_req;
    logic [7:0] line_num;
    logic       pix_valid;
    sms_color_t pix_data;
    logic       pix_ready;

    modport master (
        output line_req,
        output line_num,
        output pix_ready,
        input  pix_valid,
        input  pix_data
    );

    modport slave (
        input  line_req,
        input  line_num,
        input  pix_ready,
        output pix_valid,
        output pix_data
    );

endinterface

// File: rtl/sms_line_doubler_line_ram.sv
// Two-bank scanline store: one write port, one registered read port.
// Address MSB selects the bank, the low bits select the pixel.
module line_ram
    import vdp_pkg::*;
#(
    parameter int DEPTH = vdp_pkg::SMS_W,
    parameter int AW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  sms_color_t    wdata,
    input  logic [AW-1:0] raddr,
    output sms_color_t    rdata
);

    sms_color_t mem [2*DEPTH];
    sms_color_t rdata_q;

    // Write port.
    // NOTE: the array has no reset so the tools can map it onto block RAM;
    // unwritten entries simply show stale pixels.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Synchronous read port, one cycle of latency.
    // NOTE: non-blocking assignment keeps every flop sampling pre-edge values,
    // so ordering between always_ff blocks can never change the result.
    always_ff @(posedge clk) begin
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sms_line_doubler.sv
// Scanline ping-pong buffer and 2x scaler: requests one SMS line per two VGA
// rows, captures it into the idle bank, and replays the other bank with each
// pixel and each line doubled, centred in the frame with a backdrop border.
module sms_line_doubler
    import vdp_pkg::sms_color_t;
    import vdp_pkg::fill_state_t;
    import vdp_pkg::IDLE;
    import vdp_pkg::FILL;
    import vdp_pkg::region_t;
    import vdp_pkg::REG_BLANK;
    import vdp_pkg::REG_BORDER;
    import vdp_pkg::REG_PICTURE;
    import vdp_pkg::expand2;
#(
    parameter int H_BORDER = vdp_pkg::H_BORDER,
    parameter int V_BORDER = vdp_pkg::V_BORDER,
    parameter int SMS_W    = vdp_pkg::SMS_W,
    parameter int SMS_H    = vdp_pkg::SMS_H
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] row,
    input  logic [9:0] col,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [5:0] border_color,
    sms_line_doubler_if.master pix_if,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       underrun,
    output logic       overrun
);

    localparam int IDX_W = $clog2(SMS_W);
    localparam int AW    = IDX_W + 1;

    localparam logic [9:0]       REQ_FIRST = 10'(V_BORDER - 2);
    localparam logic [9:0]       REQ_LAST  = 10'(V_BORDER + 2*SMS_H - 4);
    localparam logic [9:0]       PIC_TOP   = 10'(V_BORDER);
    localparam logic [9:0]       PIC_BOT   = 10'(V_BORDER + 2*SMS_H);
    localparam logic [9:0]       PIC_LEFT  = 10'(H_BORDER);
    localparam logic [9:0]       PIC_RIGHT = 10'(H_BORDER + 2*SMS_W);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SMS_W - 1);

    logic [9:0] row_ext;
    assign row_ext = {1'b0, row};

    // Request tracking
    logic [8:0] row_q, row_d;
    logic       line_req_q, line_req_d;
    logic [7:0] line_num_q, line_num_d;

    // Fill FSM
    fill_state_t      state_q, state_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic             bank_q, bank_d;
    logic             underrun_q, underrun_d;
    logic             overrun_q, overrun_d;
    logic             ram_we;

    // Display pipeline
    region_t    region_q, region_d;
    sms_color_t border_q, border_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic [AW-1:0] rd_addr;
    sms_color_t ram_rdata;
    logic       in_picture;

    // Request a line on the first cycle of each even row that precedes a
    // displayed line pair; the frame wrap to row 0 is outside the window.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        row_d      = row;
        line_req_d = 1'b0;
        line_num_d = line_num_q;
        if ((row != row_q) && !row[0] &&
            (row_ext >= REQ_FIRST) && (row_ext <= REQ_LAST)) begin
            line_req_d = 1'b1;
            line_num_d = 8'((row_ext - REQ_FIRST) >> 1);
        end
    end

    // Fill FSM: capture one scanline into the bank picked by the request.
    always_comb begin
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        bank_d     = bank_q;
        underrun_d = underrun_q;
        overrun_d  = overrun_q;
        ram_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pix_if.pix_valid) begin
                    overrun_d = 1'b1;
                end
                if (line_req_q) begin
                    state_d  = FILL;
                    wr_idx_d = '0;
                    bank_d   = line_num_q[0];
                end
            end
            FILL: begin
                if (pix_if.pix_valid) begin
                    ram_we   = 1'b1;
                    wr_idx_d = wr_idx_q + 1'b1;
                    if (wr_idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end
                end
                // A new request aborts the current fill unless its final
                // pixel lands in this very cycle.
                if (line_req_q) begin
                    if (!(pix_if.pix_valid && (wr_idx_q == LAST_IDX))) begin
                        underrun_d = 1'b1;
                    end
                    state_d  = FILL;
                    wr_idx_d = '0;
                    bank_d   = line_num_q[0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_picture = (col >= PIC_LEFT) && (col < PIC_RIGHT) &&
                        (row_ext >= PIC_TOP) && (row_ext < PIC_BOT);

    // Classify the current pixel and form the read address of the display bank.
    always_comb begin
        region_d = REG_BLANK;
        rd_addr  = '0;
        border_d = sms_color_t'(border_color);
        hsync_d  = hsync_in;
        vsync_d  = vsync_in;
        if (hsync_in && vsync_in) begin
            if (in_picture) begin
                region_d = REG_PICTURE;
                rd_addr  = {1'((row_ext - PIC_TOP) >> 1),
                            IDX_W'((col - PIC_LEFT) >> 1)};
            end else begin
                region_d = REG_BORDER;
            end
        end
    end

    // All state flops, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q      <= '0;
            line_req_q <= 1'b0;
            line_num_q <= '0;
            state_q    <= IDLE;
            wr_idx_q   <= '0;
            bank_q     <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
            region_q   <= REG_BLANK;
            border_q   <= '0;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
        end else begin
            row_q      <= row_d;
            line_req_q <= line_req_d;
            line_num_q <= line_num_d;
            state_q    <= state_d;
            wr_idx_q   <= wr_idx_d;
            bank_q     <= bank_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
            region_q   <= region_d;
            border_q   <= border_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
        end
    end

    line_ram #(
        .DEPTH (SMS_W),
        .AW    (AW)
    ) u_line_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr ({bank_q, wr_idx_q}),
        .wdata (pix_if.pix_data),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // Colour expansion of the registered region, aligned with the RAM output.
    always_comb begin
        vga_r = 4'h0;
        vga_g = 4'h0;
        vga_b = 4'h0;
        case (region_q)
            REG_PICTURE: begin
                vga_r = expand2(ram_rdata.r);
                vga_g = expand2(ram_rdata.g);
                vga_b = expand2(ram_rdata.b);
            end
            REG_BORDER: begin
                vga_r = expand2(border_q.r);
                vga_g = expand2(border_q.g);
                vga_b = expand2(border_q.b);
            end
            default: ;
        endcase
    end

    assign pix_if.line_req  = line_req_q;
    assign pix_if.line_num  = line_num_q;
    assign pix_if.pix_ready = (state_q == FILL);
    assign hsync_out        = hsync_q;
    assign vsync_out        = vsync_q;
    assign underrun         = underrun_q;
    assign overrun          = overrun_q;

endmodule
